// File: rtl/button_event_decoder.sv
// -----------------------------------------------------------------------------
// button_event_decoder
//
// Turns the debounced button level and its one-cycle edge pulses into
// single-cycle user events: short press, double press, long press and
// auto-repeat while held. Downstream logic never has to time the button.
//
// Timing is derived from a prescaler that divides the clock down to 1 ms
// ticks, followed by a millisecond counter. Both restart on every state entry
// (including the self-restart in HELD after each repeat), so a timeout of N ms
// fires exactly N*T clock edges after the edge that entered the state.
// -----------------------------------------------------------------------------
module button_event_decoder #(
    parameter int unsigned CLOCK_HZ  = 10_000_000,
    parameter int unsigned LONG_MS   = 1000,
    parameter int unsigned DOUBLE_MS = 300,
    parameter int unsigned REPEAT_MS = 200
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Pressed_i,
    input  logic RisingEdge_i,
    input  logic FallingEdge_i,
    output logic ShortPress_o,
    output logic DoublePress_o,
    output logic LongPress_o,
    output logic Repeat_o,
    output logic Busy_o
);

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    localparam int unsigned TICKS_PER_MS = CLOCK_HZ / 1000;

    localparam int unsigned MAX_MS =
        (LONG_MS > DOUBLE_MS) ? ((LONG_MS   > REPEAT_MS) ? LONG_MS   : REPEAT_MS)
                              : ((DOUBLE_MS > REPEAT_MS) ? DOUBLE_MS : REPEAT_MS);

    // The ms counter only ever holds 0..N-1 before the state is left or the
    // timers restart, so $clog2(MAX_MS) bits are enough. Guard the degenerate
    // single-value cases so no counter collapses to zero width.
    localparam int unsigned PRE_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam int unsigned MS_W  = (MAX_MS > 1)       ? $clog2(MAX_MS)       : 1;

    // Terminal values: a timeout is due when the counters show N*T-1 elapsed
    // cycles, so the transition lands on edge N*T after the entry edge.
    localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(TICKS_PER_MS - 1);
    localparam logic [MS_W-1:0]  LONG_LAST   = MS_W'(LONG_MS - 1);
    localparam logic [MS_W-1:0]  DOUBLE_LAST = MS_W'(DOUBLE_MS - 1);
    localparam logic [MS_W-1:0]  REPEAT_LAST = MS_W'(REPEAT_MS - 1);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,  // waiting for a press
        ST_PRESS1 = 3'd1,  // first press in progress
        ST_GAP    = 3'd2,  // released, waiting to see if a second press follows
        ST_PRESS2 = 3'd3,  // second press in progress
        ST_HELD   = 3'd4   // long press reached, auto-repeating
    } state_t;

    state_t state_q, state_d;

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [MS_W-1:0]  ms_q,  ms_d;

    logic short_q,  short_d;
    logic double_q, double_d;
    logic long_q,   long_d;
    logic rpt_q,    rpt_d;
    logic busy_q,   busy_d;

    // Timer restart request from the FSM (HELD repeats without a state change).
    logic restart;

    // Qualified edges: a simultaneous rise and fall is illegal and ignored.
    logic rise;
    logic fall;

    // Timeout flags for each interval, evaluated against the shared timers.
    logic ms_tick;
    logic long_to;
    logic double_to;
    logic repeat_to;

    // -------------------------------------------------------------------------
    // Edge qualification and timeout decode
    // -------------------------------------------------------------------------

    // Drop both edges when they arrive together; derive the timeout strobes.
    always_comb begin
        rise      = RisingEdge_i  & ~FallingEdge_i;
        fall      = FallingEdge_i & ~RisingEdge_i;
        ms_tick   = (pre_q == PRE_LAST);
        long_to   = ms_tick && (ms_q == LONG_LAST);
        double_to = ms_tick && (ms_q == DOUBLE_LAST);
        repeat_to = ms_tick && (ms_q == REPEAT_LAST);
    end

    // -------------------------------------------------------------------------
    // FSM: next state and registered event outputs
    // -------------------------------------------------------------------------

    // Classify edges and timeouts; an edge always takes priority over a timeout.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        short_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        rpt_d    = 1'b0;
        restart  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_PRESS1;
                end
            end

            ST_PRESS1: begin
                if (fall) begin
                    state_d = ST_GAP;
                end else if (long_to) begin
                    long_d  = 1'b1;
                    state_d = ST_HELD;
                end
            end

            ST_GAP: begin
                if (rise) begin
                    state_d = ST_PRESS2;
                end else if (double_to) begin
                    short_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            ST_PRESS2: begin
                if (fall) begin
                    double_d = 1'b1;
                    state_d  = ST_IDLE;
                end else if (long_to) begin
                    // The pending double press is dropped; only the hold counts.
                    long_d  = 1'b1;
                    state_d = ST_HELD;
                end
            end

            ST_HELD: begin
                if (fall || !Pressed_i) begin
                    state_d = ST_IDLE;
                end else if (repeat_to) begin
                    rpt_d   = 1'b1;
                    restart = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Busy mirrors the next state so it is registered alongside the events.
    always_comb begin
        busy_d = (state_d != ST_IDLE);
    end

    // -------------------------------------------------------------------------
    // Timers
    // -------------------------------------------------------------------------

    // Prescaler counts 0..T-1; each wrap advances the ms counter. Both clear on
    // any state change, on a repeat restart, and stay cleared in IDLE.
    always_comb begin
        pre_d = pre_q;
        ms_d  = ms_q;
        if ((state_d != state_q) || restart || (state_q == ST_IDLE)) begin
            pre_d = '0;
            ms_d  = '0;
        end else if (ms_tick) begin
            pre_d = '0;
            ms_d  = ms_q + MS_W'(1);
        end else begin
            pre_d = pre_q + PRE_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------

    // State, timers and outputs; reset returns to IDLE with everything cleared.
    always_ff @(posedge Clock or negedge Reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this edge.
        if (!Reset) begin
            state_q  <= ST_IDLE;
            pre_q    <= '0;
            ms_q     <= '0;
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            rpt_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            ms_q     <= ms_d;
            short_q  <= short_d;
            double_q <= double_d;
            long_q   <= long_d;
            rpt_q    <= rpt_d;
            busy_q   <= busy_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign ShortPress_o  = short_q;
    assign DoublePress_o = double_q;
    assign LongPress_o   = long_q;
    assign Repeat_o      = rpt_q;
    assign Busy_o        = busy_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// -----------------------------------------------------------------------------
// tb_button_event_decoder
//
// Directed bench for button_event_decoder with T=10 cycles/ms, LONG=20 ms
// (200 cycles), DOUBLE=5 ms (50 cycles), REPEAT=4 ms (40 cycles).
// Edge index "cyc" counts rising clock edges; an input driven before edge k is
// sampled at edge k, and a registered output caused by it is seen after edge k.
// -----------------------------------------------------------------------------
module tb_button_event_decoder;

    logic Clock;
    logic Reset;
    logic Pressed_i;
    logic RisingEdge_i;
    logic FallingEdge_i;
    logic ShortPress_o;
    logic DoublePress_o;
    logic LongPress_o;
    logic Repeat_o;
    logic Busy_o;

    button_event_decoder #(
        .CLOCK_HZ (10_000),
        .LONG_MS  (20),
        .DOUBLE_MS(5),
        .REPEAT_MS(4)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Pressed_i    (Pressed_i),
        .RisingEdge_i (RisingEdge_i),
        .FallingEdge_i(FallingEdge_i),
        .ShortPress_o (ShortPress_o),
        .DoublePress_o(DoublePress_o),
        .LongPress_o  (LongPress_o),
        .Repeat_o     (Repeat_o),
        .Busy_o       (Busy_o)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int multi_hot = 0;

    // Per-output pulse bookkeeping: cycles high, first and last edge seen.
    int n_short,  f_short,  l_short;
    int n_double, f_double, l_double;
    int n_long,   f_long,   l_long;
    int n_rpt,    f_rpt,    l_rpt;

    int r0, f0, f1, f2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        n_short = 0;  f_short = -1;  l_short = -1;
        n_double = 0; f_double = -1; l_double = -1;
        n_long = 0;   f_long = -1;   l_long = -1;
        n_rpt = 0;    f_rpt = -1;    l_rpt = -1;
    endtask

    // Advance one edge, then sample outputs 1 time unit later.
    task automatic tick();
        @(posedge Clock);
        #1;
        cyc++;
        if ($countones({ShortPress_o, DoublePress_o, LongPress_o, Repeat_o}) > 1)
            multi_hot++;
        if (ShortPress_o === 1'b1) begin
            if (n_short == 0) f_short = cyc;
            l_short = cyc; n_short++;
        end
        if (DoublePress_o === 1'b1) begin
            if (n_double == 0) f_double = cyc;
            l_double = cyc; n_double++;
        end
        if (LongPress_o === 1'b1) begin
            if (n_long == 0) f_long = cyc;
            l_long = cyc; n_long++;
        end
        if (Repeat_o === 1'b1) begin
            if (n_rpt == 0) f_rpt = cyc;
            l_rpt = cyc; n_rpt++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Press: level and rise pulse sampled at the next edge (cyc after return).
    task automatic press();
        Pressed_i    = 1'b1;
        RisingEdge_i = 1'b1;
        tick();
        RisingEdge_i = 1'b0;
    endtask

    task automatic release_btn();
        Pressed_i     = 1'b0;
        FallingEdge_i = 1'b1;
        tick();
        FallingEdge_i = 1'b0;
    endtask

    task automatic check_none(input string tag);
        check({tag, "_short_n"},  n_short,  0);
        check({tag, "_double_n"}, n_double, 0);
        check({tag, "_long_n"},   n_long,   0);
        check({tag, "_rpt_n"},    n_rpt,    0);
    endtask

    initial begin
        Reset         = 1'b0;
        Pressed_i     = 1'b0;
        RisingEdge_i  = 1'b0;
        FallingEdge_i = 1'b0;
        clear_counts();

        // ---- Reset state ----
        idle(3);
        check("rst_busy",   32'(Busy_o),        32'd0);
        check("rst_short",  32'(ShortPress_o),  32'd0);
        check("rst_double", 32'(DoublePress_o), 32'd0);
        check("rst_long",   32'(LongPress_o),   32'd0);
        check("rst_rpt",    32'(Repeat_o),      32'd0);
        Reset = 1'b1;
        idle(2);

        // ---- Short press: hold 30, release, ShortPress 50 after release ----
        clear_counts();
        press(); r0 = cyc;
        check("short_busy_press1", 32'(Busy_o), 32'd1);
        idle(29);
        release_btn(); f0 = cyc;
        check("short_rel_at", f0 - r0, 30);
        check("short_busy_gap", 32'(Busy_o), 32'd1);
        idle(49);
        check("short_not_early", n_short, 0);
        idle(20);
        check("short_n",      n_short,  1);
        check("short_at",     f_short,  f0 + 50);
        check("short_double", n_double, 0);
        check("short_long",   n_long,   0);
        check("short_rpt",    n_rpt,    0);
        check("short_busy_end", 32'(Busy_o), 32'd0);

        // ---- Double press: 30 / gap 20 / 30 ----
        clear_counts();
        press();
        idle(29);
        release_btn(); f1 = cyc;
        idle(19);
        press();
        check("dbl_gap", cyc - f1, 20);
        idle(29);
        release_btn(); f2 = cyc;
        check("dbl_busy_after", 32'(Busy_o), 32'd0);
        idle(60);
        check("dbl_n",     n_double, 1);
        check("dbl_at",    f_double, f2);
        check("dbl_short", n_short,  0);
        check("dbl_long",  n_long,   0);

        // ---- Long press with repeat: hold 300 ----
        clear_counts();
        press(); r0 = cyc;
        idle(299);
        release_btn();
        check("long_rel_at", cyc - r0, 300);
        check("long_busy_rel", 32'(Busy_o), 32'd0);
        idle(60);
        check("long_n",      n_long, 1);
        check("long_at",     f_long, r0 + 200);
        check("rpt_n",       n_rpt,  2);
        check("rpt_first",   f_rpt,  r0 + 240);
        check("rpt_last",    l_rpt,  r0 + 280);
        check("long_short",  n_short,  0);
        check("long_double", n_double, 0);

        // ---- Boundary: release at 199 -> short path ----
        clear_counts();
        press(); r0 = cyc;
        idle(198);
        release_btn();
        check("b199_rel_at", cyc - r0, 199);
        idle(60);
        check("b199_long",  n_long,  0);
        check("b199_short", n_short, 1);
        check("b199_at",    f_short, r0 + 249);

        // ---- Boundary: release at 200 collides with timeout, edge wins ----
        clear_counts();
        press(); r0 = cyc;
        idle(199);
        release_btn();
        check("b200_rel_at", cyc - r0, 200);
        check("b200_busy_gap", 32'(Busy_o), 32'd1);
        idle(60);
        check("b200_long",  n_long,  0);
        check("b200_short", n_short, 1);
        check("b200_at",    f_short, r0 + 250);

        // ---- Gap boundary: second press 49 after release -> double ----
        clear_counts();
        press();
        idle(29);
        release_btn(); f1 = cyc;
        idle(48);
        press();
        check("g49_gap", cyc - f1, 49);
        idle(29);
        release_btn(); f2 = cyc;
        idle(60);
        check("g49_double", n_double, 1);
        check("g49_dbl_at", f_double, f2);
        check("g49_short",  n_short,  0);

        // ---- Gap boundary: ShortPress at +50, next press restarts at PRESS1 ----
        clear_counts();
        press();
        idle(29);
        release_btn(); f1 = cyc;
        idle(50);
        check("g50_short_at", f_short, f1 + 50);
        check("g50_busy_idle", 32'(Busy_o), 32'd0);
        press();
        idle(29);
        release_btn(); f2 = cyc;
        idle(60);
        check("g50_short_n",  n_short,  2);
        check("g50_short2",   l_short,  f2 + 50);
        check("g50_double",   n_double, 0);

        // ---- HELD: release on the repeat timeout edge -> no repeat ----
        clear_counts();
        press(); r0 = cyc;
        idle(239);
        release_btn();
        check("hrel_at", cyc - r0, 240);
        idle(60);
        check("hrel_long", n_long, 1);
        check("hrel_rpt",  n_rpt,  0);

        // ---- HELD: level drops without a fall pulse -> IDLE, no event ----
        clear_counts();
        press();
        idle(209);
        Pressed_i = 1'b0;
        tick();
        check("hlvl_busy", 32'(Busy_o), 32'd0);
        idle(60);
        check("hlvl_long", n_long, 1);
        check("hlvl_rpt",  n_rpt,  0);
        check("hlvl_short", n_short, 0);

        // ---- Reset during GAP ----
        clear_counts();
        press();
        idle(29);
        release_btn();
        idle(10);
        check("rgap_busy_before", 32'(Busy_o), 32'd1);
        #2;
        Reset = 1'b0;
        #1;
        check("rgap_busy_async",  32'(Busy_o),       32'd0);
        check("rgap_short_async", 32'(ShortPress_o), 32'd0);
        Pressed_i = 1'b1;
        idle(3);
        Reset = 1'b1;
        idle(80);
        check_none("rgap_hold");
        check("rgap_busy_hold", 32'(Busy_o), 32'd0);
        release_btn();
        idle(60);
        check_none("rgap_rel");
        check("rgap_busy_rel", 32'(Busy_o), 32'd0);
        press();
        check("rgap_fresh_busy", 32'(Busy_o), 32'd1);
        idle(29);
        release_btn(); f0 = cyc;
        idle(60);
        check("rgap_fresh_short", f_short, f0 + 50);

        // ---- Illegal simultaneous edges in IDLE ----
        clear_counts();
        RisingEdge_i  = 1'b1;
        FallingEdge_i = 1'b1;
        tick();
        RisingEdge_i  = 1'b0;
        FallingEdge_i = 1'b0;
        check("illegal_busy", 32'(Busy_o), 32'd0);
        idle(60);
        check_none("illegal");

        check("one_hot", multi_hot, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
